// File: rtl/key_debounce_module.sv
// Per-key push-button debouncer: 2-flop synchronizer, 4-state filter FSM,
// registered level plus one-cycle press / release / long-press pulses.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int LONG_CYC       = 50000000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = (LONG_CYC > 0) ? $clog2(LONG_CYC + 1) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] D_SAT  = DW'(DEBOUNCE_CYC);
  localparam logic [LW-1:0] L_LAST = (LONG_CYC > 0) ? LW'(LONG_CYC - 1) : '0;
  localparam logic [LW-1:0] L_SAT  = (LONG_CYC > 0) ? LW'(LONG_CYC) : '0;
  // Idle pin level; the synchronizer preloads it so a held key looks released after reset.
  localparam logic INACT = (KEY_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic            fired_q, fired_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            lng_q, lng_d;
  logic            p;

  // Normalized "pressed" view of the synchronized pin.
  assign p = (KEY_ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

  // Next-state and registered-output logic; one transition per cycle.
  always_comb begin
    sync_d  = {sync_q[0], pin};
    state_d = state_q;
    dcnt_d  = dcnt_q;
    lcnt_d  = lcnt_q;
    fired_d = fired_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    lng_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (p) begin
          state_d = PRESS_WAIT;
          dcnt_d  = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = RELEASED;
          dcnt_d  = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          lcnt_d  = '0;
          fired_d = 1'b0;
        end else begin
          dcnt_d = (dcnt_q == D_SAT) ? dcnt_q : dcnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DW'(1);
        end else if (LONG_CYC > 0 && !fired_q) begin
          if (lcnt_q == L_LAST) begin
            lng_d   = 1'b1;
            fired_d = 1'b1;
          end else begin
            lcnt_d = (lcnt_q == L_SAT) ? lcnt_q : lcnt_q + LW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // Bounce back to pressed keeps the long-press progress.
        if (p) begin
          state_d = PRESSED;
        end else if (dcnt_q == D_LAST) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
          level_d = 1'b0;
          dcnt_d  = '0;
          lcnt_d  = '0;
          fired_d = 1'b0;
        end else begin
          dcnt_d = (dcnt_q == D_SAT) ? dcnt_q : dcnt_q + DW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // State register with synchronous reset; pulses in flight are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {2{INACT}};
      state_q <= RELEASED;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
      fired_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      lng_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
      fired_q <= fired_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      lng_q   <= lng_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign lng   = lng_q;
endmodule

module key_debounce_module #(
  parameter int NUM_KEYS       = 4,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int LONG_CYC       = 50000000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] Key_In,
  output logic [NUM_KEYS-1:0] Key_Level,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [NUM_KEYS-1:0] Key_Long
);
  // One fully independent filter per key.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_lane #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .LONG_CYC      (LONG_CYC),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .pin  (Key_In[k]),
      .level(Key_Level[k]),
      .press(Key_Press[k]),
      .rel  (Key_Release[k]),
      .lng  (Key_Long[k])
    );
  end
endmodule

// File: tb/tb_key_debounce_module.sv
// Scoreboard bench: a run-length reference model predicts outputs at each
// clock edge; a negedge monitor pops and compares against the DUT.

module tb_key_debounce_module;
  localparam int NK = 2;
  localparam int D  = 8;
  localparam int L  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys = '1;
  logic [NK-1:0] lvl_o, prs_o, rel_o, lng_o;

  key_debounce_module #(
    .NUM_KEYS(NK), .DEBOUNCE_CYC(D), .LONG_CYC(L), .KEY_ACTIVE_LOW(1)
  ) dut (
    .CLK(clk), .RST(rst), .Key_In(keys),
    .Key_Level(lvl_o), .Key_Press(prs_o), .Key_Release(rel_o), .Key_Long(lng_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  int npress[NK], nrel[NK], nlong[NK], last_press[NK], last_long[NK];

  // Reference model: two-sample pin delay, then a level flips once the pressed
  // view has disagreed with it for D consecutive samples. Long press counts
  // samples where the key is held and was already agreeing on the prior sample.
  bit [1:0] m_pipe[NK];
  int       m_run[NK], m_hold[NK];
  bit       m_lvl[NK], m_fired[NK];
  bit       m_p;
  exp_t     e;

  always @(posedge clk) begin
    cyc++;
    e = '0;
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        m_pipe[k] = 2'b11; m_run[k] = 0; m_hold[k] = 0;
        m_lvl[k] = 1'b0; m_fired[k] = 1'b0;
      end else begin
        m_p = ~m_pipe[k][1];
        if (m_p != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = m_p; m_run[k] = 0; m_hold[k] = 0; m_fired[k] = 1'b0;
            if (m_p) e.prs[k] = 1'b1; else e.rel[k] = 1'b1;
          end
        end else begin
          if (m_lvl[k] && m_run[k] == 0 && !m_fired[k]) begin
            m_hold[k]++;
            if (m_hold[k] == L) begin e.lng[k] = 1'b1; m_fired[k] = 1'b1; end
          end
          m_run[k] = 0;
        end
        m_pipe[k] = {m_pipe[k][0], keys[k]};
      end
      e.lvl[k] = m_lvl[k];
    end
    q.push_back(e);
  end

  task automatic check_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every presented output cycle and tally DUT pulses.
  exp_t got;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      got = q.pop_front();
      check_vec("level",   lvl_o, got.lvl);
      check_vec("press",   prs_o, got.prs);
      check_vec("release", rel_o, got.rel);
      check_vec("long",    lng_o, got.lng);
      for (int k = 0; k < NK; k++) begin
        if (prs_o[k] === 1'b1) begin npress[k]++; last_press[k] = cyc; end
        if (rel_o[k] === 1'b1) nrel[k]++;
        if (lng_o[k] === 1'b1) begin nlong[k]++; last_long[k] = cyc; end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0, p0, r0, l0, rate;

  initial begin
    for (int k = 0; k < NK; k++) begin
      npress[k] = 0; nrel[k] = 0; nlong[k] = 0; last_press[k] = 0; last_long[k] = 0;
    end
    wait_n(3);
    rst = 1'b0;
    wait_n(5);

    // Clean press on key 0: pulse in the cycle after edge D+1.
    p0 = npress[0];
    keys[0] = 1'b0; t0 = cyc + 1;
    wait_n(20);
    check_int("clean_press_count", npress[0] - p0, 1);
    check_int("clean_press_latency", last_press[0] - t0, D + 1);
    check_int("key1_idle_press", npress[1], 0);
    keys[0] = 1'b1;
    wait_n(20);

    // Bounce: 3-cycle excursions, then stable low.
    p0 = npress[0]; r0 = nrel[0];
    for (int i = 0; i < 10; i++) begin
      keys[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_n(3);
    end
    keys[0] = 1'b0; t0 = cyc + 1;
    wait_n(20);
    check_int("bounce_press_count", npress[0] - p0, 1);
    check_int("bounce_press_latency", last_press[0] - t0, D + 1);
    check_int("bounce_no_release", nrel[0] - r0, 0);
    keys[0] = 1'b1;
    wait_n(20);

    // Long press: single Key_Long, L cycles after Key_Press.
    l0 = nlong[0]; r0 = nrel[0];
    keys[0] = 1'b0;
    wait_n(100);
    check_int("long_count", nlong[0] - l0, 1);
    check_int("long_latency", last_long[0] - last_press[0], L);
    keys[0] = 1'b1;
    wait_n(20);
    check_int("long_release_count", nrel[0] - r0, 1);
    check_vec("long_release_level", lvl_o, '0);

    // Short press on key 1: filtered out entirely.
    p0 = npress[1];
    keys[1] = 1'b0; wait_n(5); keys[1] = 1'b1;
    wait_n(20);
    check_int("short_press_none", npress[1] - p0, 0);

    // Simultaneous keys, then release key 1 only.
    keys = 2'b00; wait_n(20);
    keys[1] = 1'b1; wait_n(20);
    check_vec("simul_level_after_rel1", lvl_o, 2'b01);
    keys = 2'b11; wait_n(20);

    // Reset mid-filter with key 0 held.
    r0 = nrel[0]; p0 = npress[0];
    keys[0] = 1'b0; wait_n(7);
    rst = 1'b1; wait_n(2);
    rst = 1'b0; t0 = cyc + 1;
    wait_n(20);
    check_int("reset_repress_latency", last_press[0] - t0, D + 1);
    check_int("reset_repress_count", npress[0] - p0, 1);
    check_int("reset_no_release", nrel[0] - r0, 0);
    keys[0] = 1'b1; wait_n(20);

    // Randomized pins, fast then slow toggling, occasional reset.
    for (int ph = 0; ph < 2; ph++) begin
      rate = (ph == 0) ? 12 : 60;
      for (int i = 0; i < 1500; i++) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(rate - 1) == 0) keys[k] = ~keys[k];
        rst = ($urandom_range(399) == 0);
        wait_n(1);
      end
    end
    rst = 1'b0; keys = '1;
    wait_n(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
